// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: collects completed results from UNIT_NUM functional units.
// A round-robin arbiter picks one result per cycle, and a single holding register
// broadcasts it on the common data bus. The register file write port is driven
// with the resolved value in the same cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop held result, suppress grant and broadcast this cycle
//   cdb_stall           consumers cannot take a broadcast this cycle
//   unit_valid/ready    per-unit result handshake (ready is one-hot or zero)
//   unit_rsid/data/reg_en/reg_addr  packed per-unit result payloads
//   cdb_valid/rsid/data/unit        broadcast (all zero when not valid)
//   write_en/addr/is_rsid/data      register file write port (is_rsid tied 0)
//   perf_bcast_cnt, perf_conflict_cnt  only with CDB_PERF_CNT_EN defined
//
// Optional feature macro: CDB_PERF_CNT_EN (broadcast / contention counters).
module cdb_broadcaster #(
  parameter int unsigned UNIT_NUM       = 4,
  parameter int unsigned RSID_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                cdb_stall,
  input  logic [UNIT_NUM-1:0]                 unit_valid,
  output logic [UNIT_NUM-1:0]                 unit_ready,
  input  logic [UNIT_NUM*RSID_WIDTH-1:0]      unit_rsid,
  input  logic [UNIT_NUM*DATA_WIDTH-1:0]      unit_data,
  input  logic [UNIT_NUM-1:0]                 unit_reg_en,
  input  logic [UNIT_NUM*REG_ADDR_WIDTH-1:0]  unit_reg_addr,
  output logic                                cdb_valid,
  output logic [RSID_WIDTH-1:0]               cdb_rsid,
  output logic [DATA_WIDTH-1:0]               cdb_data,
  output logic [$clog2(UNIT_NUM)-1:0]         cdb_unit,
  output logic                                write_en,
  output logic [REG_ADDR_WIDTH-1:0]           write_addr,
  output logic                                write_is_rsid,
`ifdef CDB_PERF_CNT_EN
  output logic [31:0]                         perf_bcast_cnt,
  output logic [31:0]                         perf_conflict_cnt,
`endif
  output logic [DATA_WIDTH-1:0]               write_data
);

  localparam int unsigned UNIT_W = $clog2(UNIT_NUM);

  // Holding register and round-robin pointer
  logic                      hold_valid,    hold_valid_d;
  logic [RSID_WIDTH-1:0]     hold_rsid,     hold_rsid_d;
  logic [DATA_WIDTH-1:0]     hold_data,     hold_data_d;
  logic                      hold_reg_en,   hold_reg_en_d;
  logic [REG_ADDR_WIDTH-1:0] hold_reg_addr, hold_reg_addr_d;
  logic [UNIT_W-1:0]         hold_unit,     hold_unit_d;
  logic [UNIT_W-1:0]         rr_ptr,        rr_ptr_d;

  logic              can_accept;
  logic              grant_any;
  logic [UNIT_W-1:0] grant_idx;
  logic [UNIT_W:0]   cand;
  logic              bcast;

  // Round-robin search starting at rr_ptr; cand is one bit wider so the wrap is exact
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    cand       = '0;
    can_accept = !hold_valid || !cdb_stall;
    if (!rst && !flush && can_accept) begin
      for (int k = 0; k < int'(UNIT_NUM); k++) begin
        cand = (UNIT_W+1)'(rr_ptr) + (UNIT_W+1)'(k);
        if (cand >= (UNIT_W+1)'(UNIT_NUM)) begin
          cand = cand - (UNIT_W+1)'(UNIT_NUM);
        end
        if (!grant_any && unit_valid[cand[UNIT_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[UNIT_W-1:0];
        end
      end
    end
  end

  assign unit_ready = grant_any ? (UNIT_NUM'(1) << grant_idx) : '0;

  // Next-state for the holding register: flush beats grant beats drain
  always_comb begin
    hold_valid_d    = hold_valid;
    hold_rsid_d     = hold_rsid;
    hold_data_d     = hold_data;
    hold_reg_en_d   = hold_reg_en;
    hold_reg_addr_d = hold_reg_addr;
    hold_unit_d     = hold_unit;
    rr_ptr_d        = rr_ptr;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (grant_any) begin
      hold_valid_d    = 1'b1;
      hold_rsid_d     = unit_rsid[grant_idx*RSID_WIDTH +: RSID_WIDTH];
      hold_data_d     = unit_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      hold_reg_en_d   = unit_reg_en[grant_idx];
      hold_reg_addr_d = unit_reg_addr[grant_idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      hold_unit_d     = grant_idx;
      rr_ptr_d        = (grant_idx == UNIT_W'(UNIT_NUM - 1)) ? '0 : grant_idx + UNIT_W'(1);
    end else if (hold_valid && !cdb_stall) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid    <= 1'b0;
      hold_rsid     <= '0;
      hold_data     <= '0;
      hold_reg_en   <= 1'b0;
      hold_reg_addr <= '0;
      hold_unit     <= '0;
      rr_ptr        <= '0;
    end else begin
      hold_valid    <= hold_valid_d;
      hold_rsid     <= hold_rsid_d;
      hold_data     <= hold_data_d;
      hold_reg_en   <= hold_reg_en_d;
      hold_reg_addr <= hold_reg_addr_d;
      hold_unit     <= hold_unit_d;
      rr_ptr        <= rr_ptr_d;
    end
  end

  // Broadcast straight out of the holding register; every field zeroed when idle
  assign bcast         = hold_valid && !cdb_stall && !flush && !rst;
  assign cdb_valid     = bcast;
  assign cdb_rsid      = bcast ? hold_rsid : '0;
  assign cdb_data      = bcast ? hold_data : '0;
  assign cdb_unit      = bcast ? hold_unit : '0;
  assign write_en      = bcast && hold_reg_en && (hold_reg_addr != '0);
  assign write_addr    = bcast ? hold_reg_addr : '0;
  assign write_data    = bcast ? hold_data : '0;
  assign write_is_rsid = 1'b0;

`ifdef CDB_PERF_CNT_EN
  logic conflict;
  assign conflict = ($countones(unit_valid) >= 2) || ((|unit_valid) && !grant_any);

  // Free-running counters; flush does not clear them
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bcast_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (bcast)    perf_bcast_cnt    <= perf_bcast_cnt + 32'd1;
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Result-side counterpart to the register file's RS-tagged write channel.
- Collects completed results from UNIT_NUM functional units. Each result carries the producing reservation-station id, the data and an optional destination register.
- Arbitrates round-robin and broadcasts one result per cycle on the common data bus (CDB). The CDB feeds the reservation stations.
- Drives the register file write port with the resolved value (write_is_rsid = 0) in the same cycle.

Parameters:
UNIT_NUM, 4, number of functional-unit result ports (2..8)
RSID_WIDTH, 5, width of reservation-station id
DATA_WIDTH, 32, result width (matches DATA_BUS)
REG_ADDR_WIDTH, 5, register address width (matches REG_ADDR_BUS)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard every pending and held result (mispredict/exception)
cdb_stall  in  1  consumers cannot take a broadcast this cycle
unit_valid  in  UNIT_NUM  unit i presents a result
unit_ready  out  UNIT_NUM  unit i's result accepted this cycle
unit_rsid  in  UNIT_NUM*RSID_WIDTH  packed producer ids, unit i at [i*RSID_WIDTH +: RSID_WIDTH]
unit_data  in  UNIT_NUM*DATA_WIDTH  packed result data
unit_reg_en  in  UNIT_NUM  result writes a destination register
unit_reg_addr  in  UNIT_NUM*REG_ADDR_WIDTH  packed destination register addresses
cdb_valid  out  1  broadcast valid
cdb_rsid  out  RSID_WIDTH  broadcast producer id
cdb_data  out  DATA_WIDTH  broadcast data
cdb_unit  out  clog2(UNIT_NUM)  index of the unit that produced the broadcast
write_en  out  1  register file write enable
write_addr  out  REG_ADDR_WIDTH  register file write address
write_is_rsid  out  1  tied 0: broadcasts always carry values
write_data  out  DATA_WIDTH  register file write data

Behaviour:
- Structure: one output holding register (hold_valid, rsid, data, reg_en, reg_addr, unit) plus round-robin pointer rr_ptr.
- Reset (rst=1 at posedge):
  - hold_valid=0, rr_ptr=0.
  - All cdb_* and write_* outputs 0.
  - unit_ready=0 while rst is high.
- Outputs driven directly from the holding register:
  - cdb_valid = write_en source = hold_valid && !cdb_stall.
  - write_en = cdb_valid && hold_reg_en && (hold_reg_addr != 0).
  - With cdb_valid=0, cdb_rsid, cdb_data and write_* drive 0.
- can_accept = !hold_valid || !cdb_stall, i.e. the register is empty or is being drained this cycle.
- Grant (combinational):
  - If can_accept && !flush, pick the first i with unit_valid[i], searching from rr_ptr upward with wrap.
  - unit_ready is one-hot at the granted index, else all-zero.
  - Handshake completes when unit_valid[i] && unit_ready[i].
- On grant, at the posedge:
  - Load the holding register from unit i.
  - hold_valid=1.
  - rr_ptr = (i+1) mod UNIT_NUM.
- Latency: a result accepted in cycle N is broadcast in cycle N+1 unless stalled.
- Throughput: 1 result/cycle sustained with cdb_stall=0.
- Drain without grant: the register is broadcast (cdb_stall=0) and no unit is valid → hold_valid=0.
- Stall: the holding register is frozen, outputs are suppressed and no grant is issued. Units must hold valid and payload stable until ready.
- Fairness: any continuously valid unit is granted within UNIT_NUM grants. rr_ptr advances only on a grant.
- Flush: at posedge hold_valid=0, no grant that cycle, cdb_valid=0 that cycle. rr_ptr is unchanged.
- Precedence: rst > flush > normal.
- A reset or flush mid-stall drops the held result silently.
- A unit that deasserts valid without being granted is legal; no state is kept for it.
- Register 0 is never written, but its rsid still broadcasts on the CDB.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_bcast_cnt [31:0]: increments every cycle cdb_valid=1.
  - perf_conflict_cnt [31:0]: increments every cycle with at least two bits of unit_valid set, or any unit_valid bit set but no grant.
- Both counters reset to 0, wrap at 2^32 and are not cleared by flush.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset, then unit_valid=4'b0001, rsid=3, data=0xDEADBEEF, reg_en=1, addr=7 → next cycle cdb_valid=1, cdb_rsid=3, cdb_data=0xDEADBEEF, write_en=1, write_addr=7, write_is_rsid=0.
- All four units valid continuously from rr_ptr=0 → grants 0,1,2,3,0 on consecutive cycles; one broadcast per cycle.
- Hold result, cdb_stall=1 for 3 cycles → cdb_valid=0 and unit_ready=0 throughout; result broadcast in the cycle stall drops; no loss or duplicate.
- reg_en=1, addr=0, rsid=9 → cdb_valid=1, cdb_rsid=9, write_en=0.
- Result held under stall, flush=1 → next cycle cdb_valid=0, dropped rsid never appears; rr_ptr unchanged.
- With CDB_PERF_CNT_EN, 10 broadcasts including 4 contended cycles → perf_bcast_cnt=10, perf_conflict_cnt=4; rst clears both.
